// File: rtl/charge_time_display_if.sv
// Display-stage bundle: packed BCD time and enable in, segment/anode drive and error flag out.
// master = time source / display board side, slave = charge_time_display.
interface charge_time_display_if;
  logic [11:0] PresentTime;
  logic        DispEnable;
  logic [6:0]  Seg;
  logic        Dp;
  logic [2:0]  Anode;
  logic        BcdError;

  modport master (
    output PresentTime, DispEnable,
    input  Seg, Dp, Anode, BcdError
  );

  modport slave (
    input  PresentTime, DispEnable,
    output Seg, Dp, Anode, BcdError
  );
endinterface

// File: rtl/charge_time_display.sv
// Countdown display stage: 3-digit multiplexed common-anode 7-seg (M.SS), frame-sampled time.
// Ports: Clk, nReset (sync, active-low), bus (slave): PresentTime, DispEnable -> Seg, Dp, Anode, BcdError.
// Option: define LOW_TIME_BLINK_EN to blank the display on a slow blink while 0 < time < LOW_THRESH.
module charge_time_display #(
  parameter int          REFRESH_DIV = 1000,
  parameter int          BLINK_DIV   = 25_000_000,
  parameter logic [11:0] LOW_THRESH  = 12'h010
) (
  input logic                  Clk,
  input logic                  nReset,
  charge_time_display_if.slave bus
);

  if (REFRESH_DIV < 1 || BLINK_DIV < 1 || LOW_THRESH > 12'h999) begin : g_bad_cfg
    $error("charge_time_display: illegal parameter value");
  end

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic [11:0]   shadow;
  logic          first;
  logic          bcd_err;
  logic [6:0]    seg;
  logic          dp;
  logic [2:0]    anode;

  logic          slot_end;
  logic          wrap;
  logic [3:0]    nib;
  logic          blank;

  function automatic logic [6:0] decode(input logic [3:0] d, input logic tens);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    if (tens && d > 4'd5) s = SEG_DASH;
    return s;
  endfunction

  function automatic logic bad_time(input logic [11:0] t);
    return (t[11:8] > 4'd9) || (t[7:4] > 4'd5) || (t[3:0] > 4'd9);
  endfunction

  assign slot_end = (div == DIV_LAST);
  assign wrap     = slot_end && (idx == 2'd2);

  always_comb begin
    nib = shadow[3:0];
    unique case (idx)
      2'd1:    nib = shadow[7:4];
      2'd2:    nib = shadow[11:8];
      default: nib = shadow[3:0];
    endcase
  end

`ifdef LOW_TIME_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Valid packed BCD orders the same as plain binary, so a direct compare works.
  assign blank = blink_phase && !bcd_err &&
                 (shadow != 12'h000) && (shadow < LOW_THRESH);
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      div     <= '0;
      idx     <= 2'd0;
      shadow  <= 12'h000;
      first   <= 1'b1;
      bcd_err <= 1'b0;
      seg     <= SEG_OFF;
      dp      <= 1'b1;
      anode   <= 3'b111;
    end else begin
      first <= 1'b0;

      if (slot_end) begin
        div <= '0;
        idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end else begin
        div <= div + 1'b1;
      end

      // One snapshot per frame keeps all three digits consistent.
      if (first || wrap) begin
        shadow  <= bus.PresentTime;
        bcd_err <= bad_time(bus.PresentTime);
      end

      if (bus.DispEnable && !blank) begin
        seg <= decode(nib, idx == 2'd1);
        dp  <= (idx != 2'd2);
        unique case (idx)
          2'd0:    anode <= 3'b110;
          2'd1:    anode <= 3'b101;
          2'd2:    anode <= 3'b011;
          default: anode <= 3'b111;
        endcase
      end else begin
        seg   <= SEG_OFF;
        dp    <= 1'b1;
        anode <= 3'b111;
      end
    end
  end

  assign bus.Seg      = seg;
  assign bus.Dp       = dp;
  assign bus.Anode    = anode;
  assign bus.BcdError = bcd_err;

endmodule
